// File: rtl/gate_op_pkg.sv
// gate_op_pkg: shared definitions for the gate-op scheduler.
//   - 3-bit op codes for the bitwise gate unit (AND..NOT, plus one reserved code)
//   - self-test vector count and sweep FSM state encodings
//   - golden_bit(): reference truth table for one bit of a gate op. It is
//     written as truth-table constants so it does not share logic with
//     gate_eval_unit.
package gate_op_pkg;

  localparam logic [2:0] OP_AND  = 3'd0;
  localparam logic [2:0] OP_OR   = 3'd1;
  localparam logic [2:0] OP_NAND = 3'd2;
  localparam logic [2:0] OP_NOR  = 3'd3;
  localparam logic [2:0] OP_XOR  = 3'd4;
  localparam logic [2:0] OP_XNOR = 3'd5;
  localparam logic [2:0] OP_NOT  = 3'd6;
  localparam logic [2:0] OP_RSVD = 3'd7;

  // 7 ops x 4 operand-bit combinations
  localparam int SWEEP_VECTORS = 28;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } sweep_state_t;

  // Truth table indexed by {a,b}: bit 3 = (1,1), bit 0 = (0,0).
  function automatic logic golden_bit(input logic [2:0] op, input logic a, input logic b);
    logic [3:0] tt;
    case (op)
      OP_AND:  tt = 4'b1000;
      OP_OR:   tt = 4'b1110;
      OP_NAND: tt = 4'b0111;
      OP_NOR:  tt = 4'b0001;
      OP_XOR:  tt = 4'b0110;
      OP_XNOR: tt = 4'b1001;
      OP_NOT:  tt = 4'b0011;
      default: tt = 4'b0000;
    endcase
    return tt[{a, b}];
  endfunction

endpackage

// File: rtl/gate_eval_unit.sv
// gate_eval_unit: combinational bitwise gate evaluator.
// Ports:
//   op  in  3  op code (see gate_op_pkg)
//   a   in  W  operand a
//   b   in  W  operand b (ignored by NOT)
//   y   out W  result; 0 for the reserved op
//   err out 1  set when the reserved op code is used
module gate_eval_unit
  import gate_op_pkg::*;
#(
  parameter int W = 8
) (
  input  logic [2:0]   op,
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  output logic [W-1:0] y,
  output logic         err
);

  // NOTE: every output gets a default before the case so no path leaves it
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    y   = '0;
    err = 1'b0;
    case (op)
      OP_AND:  y = a & b;
      OP_OR:   y = a | b;
      OP_NAND: y = ~(a & b);
      OP_NOR:  y = ~(a | b);
      OP_XOR:  y = a ^ b;
      OP_XNOR: y = ~(a ^ b);
      OP_NOT:  y = ~a;
      default: err = 1'b1;
    endcase
  end

endmodule

// File: rtl/gate_op_scheduler.sv
// gate_op_scheduler: shares one gate_eval_unit among NREQ requesters with
// round-robin arbitration and a single registered, id-tagged response.
// Optional self-test (macro GATE_OP_SCHED_SWEEP_EN) sweeps the full truth
// table of every op through the shared unit in otherwise idle cycles.
// Ports:
//   clk, rst                     clock, synchronous active-high reset
//   req_valid/req_ready [NREQ]   per-requester handshake (ready is one-hot or 0)
//   req_op [NREQ*3]              op code, requester i at [3i+2:3i]
//   req_a, req_b [NREQ*W]        operands, requester i at [W*i+W-1:W*i]
//   rsp_valid/rsp_ready          response handshake
//   rsp_id [IDW], rsp_y [W]      served requester and result
//   rsp_err                      reserved op code was used
//   sweep_start/busy/done/pass   self-test control and verdict (0 when disabled)
module gate_op_scheduler
  import gate_op_pkg::*;
#(
  parameter int  NREQ = 4,
  parameter int  W    = 8,
  localparam int IDW  = $clog2(NREQ)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [NREQ-1:0]   req_valid,
  output logic [NREQ-1:0]   req_ready,
  input  logic [NREQ*3-1:0] req_op,
  input  logic [NREQ*W-1:0] req_a,
  input  logic [NREQ*W-1:0] req_b,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [IDW-1:0]    rsp_id,
  output logic [W-1:0]      rsp_y,
  output logic              rsp_err,
  input  logic              sweep_start,
  output logic              sweep_busy,
  output logic              sweep_done,
  output logic              sweep_pass
);

  logic [IDW-1:0] ptr;
  logic [IDW-1:0] grant;
  logic [IDW-1:0] scan_idx;
  logic           any_valid;
  logic           out_free;
  logic           transfer;

  logic [2:0]     eval_op;
  logic [W-1:0]   eval_a;
  logic [W-1:0]   eval_b;
  logic [W-1:0]   eval_y;
  logic           eval_err;

  // Round-robin grant: scan from the highest offset down so the lowest
  // offset from ptr that is valid wins.
  always_comb begin
    grant     = ptr;
    any_valid = 1'b0;
    scan_idx  = '0;
    for (int k = NREQ - 1; k >= 0; k--) begin
      scan_idx = IDW'((int'(ptr) + k) % NREQ);
      if (req_valid[scan_idx]) begin
        grant     = scan_idx;
        any_valid = 1'b1;
      end
    end
  end

  assign out_free = !rsp_valid || rsp_ready;
  assign transfer = any_valid && out_free;

  always_comb begin
    req_ready = '0;
    if (transfer) req_ready[grant] = 1'b1;
  end

`ifdef GATE_OP_SCHED_SWEEP_EN
  sweep_state_t state, state_next;
  logic [4:0]   vec_idx;
  logic         fail;
  logic         sweep_step;
  logic         sweep_last;
  logic         mismatch;
  logic [2:0]   sweep_op;
  logic         sweep_a;
  logic         sweep_b;

  // Vector index encodes {op[2:0], a, b}, so ops 0..6 cover indices 0..27.
  assign sweep_op   = vec_idx[4:2];
  assign sweep_a    = vec_idx[1];
  assign sweep_b    = vec_idx[0];
  // Requests always win the shared unit; the sweep only advances when idle.
  assign sweep_step = (state == S_RUN) && !any_valid;
  assign sweep_last = (vec_idx == 5'(SWEEP_VECTORS - 1));
  assign mismatch   = eval_err ||
                      (eval_y != {W{golden_bit(sweep_op, sweep_a, sweep_b)}});
`endif

  always_comb begin
    eval_op = req_op[3*int'(grant) +: 3];
    eval_a  = req_a[W*int'(grant) +: W];
    eval_b  = req_b[W*int'(grant) +: W];
`ifdef GATE_OP_SCHED_SWEEP_EN
    if (!any_valid) begin
      eval_op = sweep_op;
      eval_a  = {W{sweep_a}};
      eval_b  = {W{sweep_b}};
    end
`endif
  end

  gate_eval_unit #(.W(W)) u_eval (
    .op  (eval_op),
    .a   (eval_a),
    .b   (eval_b),
    .y   (eval_y),
    .err (eval_err)
  );

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      rsp_valid <= 1'b0;
      rsp_y     <= '0;
      rsp_id    <= '0;
      rsp_err   <= 1'b0;
      ptr       <= '0;
    end else if (transfer) begin
      rsp_valid <= 1'b1;
      rsp_y     <= eval_y;
      rsp_id    <= grant;
      rsp_err   <= eval_err;
      ptr       <= (grant == IDW'(NREQ - 1)) ? '0 : grant + 1'b1;
    end else if (rsp_ready) begin
      rsp_valid <= 1'b0;
    end
  end

`ifdef GATE_OP_SCHED_SWEEP_EN
  always_ff @(posedge clk) begin
    if (rst) state <= S_IDLE;
    else     state <= state_next;
  end

  always_comb begin
    state_next = state;
    sweep_busy = 1'b0;
    sweep_done = 1'b0;
    case (state)
      S_IDLE: if (sweep_start) state_next = S_RUN;
      S_RUN: begin
        sweep_busy = 1'b1;
        if (sweep_step && sweep_last) state_next = S_DONE;
      end
      S_DONE: begin
        sweep_done = 1'b1;
        state_next = S_IDLE;
      end
      default: state_next = S_IDLE;
    endcase
  end

  // The verdict is written on the last vector so it is already valid
  // during the sweep_done pulse.
  always_ff @(posedge clk) begin
    if (rst) begin
      vec_idx    <= '0;
      fail       <= 1'b0;
      sweep_pass <= 1'b0;
    end else if (state == S_IDLE && sweep_start) begin
      vec_idx    <= '0;
      fail       <= 1'b0;
      sweep_pass <= 1'b0;
    end else if (sweep_step) begin
      vec_idx <= vec_idx + 5'd1;
      if (mismatch) fail <= 1'b1;
      if (sweep_last) sweep_pass <= !(fail || mismatch);
    end
  end
`else
  logic sweep_start_unused;
  assign sweep_start_unused = sweep_start;
  assign sweep_busy         = 1'b0;
  assign sweep_done         = 1'b0;
  assign sweep_pass         = 1'b0;
`endif

endmodule

// File: tb/tb_gate_op_scheduler.sv
// Directed self-checking bench for gate_op_scheduler (NREQ=4, W=8).
// Sweep scenarios are compiled in when GATE_OP_SCHED_SWEEP_EN is defined;
// otherwise the bench checks that the sweep outputs stay low.
module tb_gate_op_scheduler;

  localparam int NREQ = 4;
  localparam int W    = 8;
  localparam int IDW  = 2;

  logic              clk = 1'b0;
  logic              rst;
  logic [NREQ-1:0]   req_valid;
  logic [NREQ-1:0]   req_ready;
  logic [NREQ*3-1:0] req_op;
  logic [NREQ*W-1:0] req_a;
  logic [NREQ*W-1:0] req_b;
  logic              rsp_valid;
  logic              rsp_ready;
  logic [IDW-1:0]    rsp_id;
  logic [W-1:0]      rsp_y;
  logic              rsp_err;
  logic              sweep_start;
  logic              sweep_busy;
  logic              sweep_done;
  logic              sweep_pass;

  int passed = 0;
  int total  = 0;

  always #5 clk = ~clk;

  gate_op_scheduler #(.NREQ(NREQ), .W(W)) dut (
    .clk         (clk),
    .rst         (rst),
    .req_valid   (req_valid),
    .req_ready   (req_ready),
    .req_op      (req_op),
    .req_a       (req_a),
    .req_b       (req_b),
    .rsp_valid   (rsp_valid),
    .rsp_ready   (rsp_ready),
    .rsp_id      (rsp_id),
    .rsp_y       (rsp_y),
    .rsp_err     (rsp_err),
    .sweep_start (sweep_start),
    .sweep_busy  (sweep_busy),
    .sweep_done  (sweep_done),
    .sweep_pass  (sweep_pass)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input int i, input logic v, input logic [2:0] op,
                         input logic [W-1:0] a, input logic [W-1:0] b);
    req_valid[i]      = v;
    req_op[3*i +: 3]  = op;
    req_a[W*i +: W]   = a;
    req_b[W*i +: W]   = b;
  endtask

  task automatic do_reset();
    rst         = 1'b1;
    req_valid   = '0;
    req_op      = '0;
    req_a       = '0;
    req_b       = '0;
    rsp_ready   = 1'b1;
    sweep_start = 1'b0;
    tick();
    tick();
    rst = 1'b0;
  endtask

  task automatic set_all_or();
    for (int i = 0; i < NREQ; i++) set_req(i, 1'b1, 3'd1, 8'(16 * i), 8'h01);
  endtask

  task automatic test_reset();
    do_reset();
    total++;
    if ({rsp_valid, rsp_err, rsp_id, rsp_y} !== 12'h000)
      $display("FAIL reset_rsp got v=%b e=%b id=%0d y=%h want all 0", rsp_valid, rsp_err, rsp_id, rsp_y);
    else passed++;
    total++;
    if (req_ready !== 4'b0000) $display("FAIL reset_ready got %b want 0000", req_ready);
    else passed++;
    total++;
    if ({sweep_busy, sweep_done, sweep_pass} !== 3'b000)
      $display("FAIL reset_sweep got %b want 000", {sweep_busy, sweep_done, sweep_pass});
    else passed++;
  endtask

  task automatic test_single();
    set_req(0, 1'b1, 3'd4, 8'hF0, 8'h3C);
    #1;
    total++;
    if (req_ready !== 4'b0001) $display("FAIL single_ready got %b want 0001", req_ready);
    else passed++;
    tick();
    set_req(0, 1'b0, 3'd4, 8'hF0, 8'h3C);
    total++;
    if ({rsp_valid, rsp_id, rsp_err, rsp_y} !== {1'b1, 2'd0, 1'b0, 8'hCC})
      $display("FAIL single_rsp got v=%b id=%0d e=%b y=%h want v=1 id=0 e=0 y=cc", rsp_valid, rsp_id, rsp_err, rsp_y);
    else passed++;
    tick();
    total++;
    if (rsp_valid !== 1'b0) $display("FAIL single_drain got v=%b want 0", rsp_valid);
    else passed++;
  endtask

  task automatic test_round_robin();
    do_reset();
    set_all_or();
    for (int k = 0; k < 8; k++) begin
      int g;
      logic [W-1:0] ey;
      g  = k % NREQ;
      ey = 8'(16 * g) | 8'h01;
      #1;
      total++;
      if (req_ready !== 4'(1 << g)) $display("FAIL rr_grant%0d got %b want %b", k, req_ready, 4'(1 << g));
      else passed++;
      tick();
      total++;
      if ({rsp_valid, rsp_id, rsp_y} !== {1'b1, 2'(g), ey})
        $display("FAIL rr_rsp%0d got v=%b id=%0d y=%h want v=1 id=%0d y=%h", k, rsp_valid, rsp_id, rsp_y, g, ey);
      else passed++;
    end
    req_valid = '0;
    tick();
  endtask

  task automatic test_back_pressure();
    do_reset();
    set_all_or();
    #1;
    tick();
    rsp_ready = 1'b0;
    #1;
    total++;
    if (req_ready !== 4'b0000) $display("FAIL bp_ready0 got %b want 0000", req_ready);
    else passed++;
    for (int k = 0; k < 3; k++) begin
      tick();
      total++;
      if ({rsp_valid, rsp_id, rsp_y, req_ready} !== {1'b1, 2'd0, 8'h01, 4'b0000})
        $display("FAIL bp_hold%0d got v=%b id=%0d y=%h rdy=%b want v=1 id=0 y=01 rdy=0000", k, rsp_valid, rsp_id, rsp_y, req_ready);
      else passed++;
    end
    rsp_ready = 1'b1;
    #1;
    total++;
    if (req_ready !== 4'b0010) $display("FAIL bp_release got %b want 0010", req_ready);
    else passed++;
    tick();
    total++;
    if ({rsp_valid, rsp_id, rsp_y} !== {1'b1, 2'd1, 8'h11})
      $display("FAIL bp_next got v=%b id=%0d y=%h want v=1 id=1 y=11", rsp_valid, rsp_id, rsp_y);
    else passed++;
    req_valid = '0;
    tick();
    tick();
  endtask

  task automatic test_ops();
    logic [2:0]   ops  [8] = '{3'd0, 3'd1, 3'd2, 3'd3, 3'd4, 3'd5, 3'd6, 3'd7};
    logic [W-1:0] as   [8] = '{8'hF0, 8'hF0, 8'hF0, 8'hF0, 8'hF0, 8'hF0, 8'hA5, 8'hFF};
    logic [W-1:0] bs   [8] = '{8'h3C, 8'h3C, 8'h3C, 8'h3C, 8'h3C, 8'h3C, 8'h3C, 8'hFF};
    logic [W-1:0] ys   [8] = '{8'h30, 8'hFC, 8'hCF, 8'h03, 8'hCC, 8'h33, 8'h5A, 8'h00};
    logic         errs [8] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
    rsp_ready = 1'b1;
    for (int k = 0; k < 8; k++) begin
      int i;
      i = k % NREQ;
      set_req(i, 1'b1, ops[k], as[k], bs[k]);
      #1;
      total++;
      if (req_ready[i] !== 1'b1) $display("FAIL op%0d_ready got %b want bit %0d set", k, req_ready, i);
      else passed++;
      tick();
      set_req(i, 1'b0, ops[k], as[k], bs[k]);
      total++;
      if ({rsp_valid, rsp_id, rsp_y, rsp_err} !== {1'b1, 2'(i), ys[k], errs[k]})
        $display("FAIL op%0d_rsp got v=%b id=%0d y=%h e=%b want v=1 id=%0d y=%h e=%b", k, rsp_valid, rsp_id, rsp_y, rsp_err, i, ys[k], errs[k]);
      else passed++;
    end
    tick();
  endtask

  task automatic test_reset_mid();
    rsp_ready = 1'b1;
    set_req(1, 1'b1, 3'd0, 8'hFF, 8'h0F);
    #1;
    tick();
    set_req(1, 1'b0, 3'd0, 8'hFF, 8'h0F);
    rsp_ready = 1'b0;
    tick();
    total++;
    if (rsp_valid !== 1'b1) $display("FAIL mid_pending got v=%b want 1", rsp_valid);
    else passed++;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    total++;
    if ({rsp_valid, rsp_y} !== 9'h000) $display("FAIL mid_drop got v=%b y=%h want v=0 y=00", rsp_valid, rsp_y);
    else passed++;
    set_all_or();
    #1;
    total++;
    if (req_ready !== 4'b0001) $display("FAIL mid_ptr got %b want 0001", req_ready);
    else passed++;
    req_valid = '0;
    rsp_ready = 1'b1;
    set_req(2, 1'b1, 3'd4, 8'h0F, 8'hFF);
    #1;
    tick();
    req_valid = '0;
    total++;
    if ({rsp_valid, rsp_id, rsp_y} !== {1'b1, 2'd2, 8'hF0})
      $display("FAIL mid_req2 got v=%b id=%0d y=%h want v=1 id=2 y=f0", rsp_valid, rsp_id, rsp_y);
    else passed++;
    tick();
  endtask

`ifdef GATE_OP_SCHED_SWEEP_EN
  task automatic test_sweep(input bit stall);
    int n;
    int rsp_seen;
    do_reset();
    sweep_start = 1'b1;
    tick();
    sweep_start = 1'b0;
    total++;
    if ({sweep_busy, sweep_pass} !== 2'b10) $display("FAIL sweep%0d_start got busy=%b pass=%b want 1 0", stall, sweep_busy, sweep_pass);
    else passed++;
    n = 0;
    rsp_seen = 0;
    while (sweep_busy && n < 100) begin
      n++;
      if (rsp_valid) rsp_seen++;
      sweep_start = (n == 5);
      if (stall && n == 10) set_req(1, 1'b1, 3'd1, 8'h00, 8'h42);
      if (stall && n == 15) set_req(1, 1'b0, 3'd1, 8'h00, 8'h42);
      tick();
    end
    sweep_start = 1'b0;
    total++;
    if (n !== (stall ? 33 : 28)) $display("FAIL sweep%0d_len got %0d want %0d", stall, n, stall ? 33 : 28);
    else passed++;
    total++;
    if ({sweep_done, sweep_pass} !== 2'b11) $display("FAIL sweep%0d_verdict got done=%b pass=%b want 1 1", stall, sweep_done, sweep_pass);
    else passed++;
    total++;
    if (rsp_seen !== (stall ? 5 : 0)) $display("FAIL sweep%0d_rsp got %0d want %0d", stall, rsp_seen, stall ? 5 : 0);
    else passed++;
    tick();
    total++;
    if ({sweep_busy, sweep_done, sweep_pass} !== 3'b001)
      $display("FAIL sweep%0d_after got %b want 001", stall, {sweep_busy, sweep_done, sweep_pass});
    else passed++;
  endtask
`else
  task automatic test_sweep_disabled();
    logic seen;
    seen = 1'b0;
    sweep_start = 1'b1;
    tick();
    sweep_start = 1'b0;
    for (int k = 0; k < 40; k++) begin
      seen = seen | sweep_busy | sweep_done | sweep_pass;
      tick();
    end
    total++;
    if (seen !== 1'b0) $display("FAIL sweep_disabled got activity=%b want 0", seen);
    else passed++;
  endtask
`endif

  initial begin
    #200000;
    $display("FAIL watchdog got timeout want completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    test_reset();
    test_single();
    test_round_robin();
    test_back_pressure();
    test_ops();
    test_reset_mid();
`ifdef GATE_OP_SCHED_SWEEP_EN
    test_sweep(1'b0);
    test_sweep(1'b1);
`else
    test_sweep_disabled();
`endif
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/gate_op_scheduler.md
Name: gate_op_scheduler

Overview:
- Shares one bitwise gate-evaluation unit (AND/OR/NAND/NOR/XOR/XNOR/NOT) between NREQ requesters.
- Round-robin arbitration and a valid/ready request interface per requester.
- One registered response channel tagged with the requester id.
- Sits between student-lab stimulus sources and the gate datapath; the optional self-test sweeps the full truth table of every op.

Parameters:
- NREQ, 4, number of requesters (2..8)
- W, 8, operand/result width in bits
- IDW, $clog2(NREQ), requester id width (derived, not overridden)

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  synchronous active-high reset
- req_valid  in  NREQ  per-requester request valid
- req_ready  out  NREQ  per-requester accept (one-hot or zero)
- req_op  in  NREQ*3  op codes; requester i at [3i+2:3i]
- req_a  in  NREQ*W  operand a; requester i at [W*i+W-1:W*i]
- req_b  in  NREQ*W  operand b; same packing as req_a
- rsp_valid  out  1  response valid
- rsp_ready  in  1  response consumer ready
- rsp_id  out  IDW  index of the requester served
- rsp_y  out  W  result
- rsp_err  out  1  reserved op code used
- sweep_start  in  1  start self-test (pulse)
- sweep_busy  out  1  self-test running
- sweep_done  out  1  one-cycle pulse at self-test end
- sweep_pass  out  1  self-test verdict, held until next start

Behaviour:
- Clock and reset: one clock `clk`; reset `rst` is synchronous and active-high.
- Reset values: rsp_valid=0, rsp_y=0, rsp_id=0, rsp_err=0, RR pointer=0, sweep FSM=IDLE, sweep_busy=0, sweep_done=0, sweep_pass=0.
- Reset mid-operation: any held response is dropped and any sweep is aborted.
- Op encoding: 0 AND, 1 OR, 2 NAND, 3 NOR, 4 XOR, 5 XNOR, 6 NOT a (b ignored), 7 reserved (y=0, err=1).
- out_free = !rsp_valid || rsp_ready.
- Grant: combinational; the first asserted req_valid scanning from ptr upward, modulo NREQ.
- req_ready[g]=1 only for the granted index, and only when out_free; all other bits are 0.
- req_ready never depends on rsp_valid of the same cycle except through out_free.
- Transfer = req_valid[g] && req_ready[g].
  - Next cycle: rsp_valid=1, rsp_y=f(op,a,b), rsp_id=g, rsp_err=(op==7).
  - ptr <= (g+1) mod NREQ.
- Latency: exactly 1 cycle from transfer to rsp_valid.
- Throughput: 1 per cycle while rsp_ready=1.
- Backpressure: while rsp_valid && !rsp_ready, rsp_* are held stable, all req_ready=0, and ptr does not change.
- rsp_valid falls after the consumed cycle if no new transfer occurs in that cycle.
- No request valid: ptr holds and the output drains normally.
- Requesters may drop req_valid without a transfer; no starvation, since each requester waits at most NREQ-1 grants.

Optional Feature:
- Macro: GATE_OP_SCHED_SWEEP_EN.
- Defined: sweep FSM with states IDLE, RUN, DONE.
  - IDLE: sweep_start=1 -> RUN; vector index cleared; fail flag cleared; sweep_pass cleared.
  - RUN: sweep_busy=1. Steps through op 0..6 × (a,b) ∈ {00,01,10,11}, 28 vectors. Each operand bit is replicated across W bits.
  - RUN uses the shared unit only in cycles where no req_valid bit is set, so it has lowest priority and stalls otherwise.
  - Each result is compared against an independent golden expression; a mismatch sets a sticky fail flag.
  - Sweep results never appear on rsp_*.
  - After vector 27: DONE for 1 cycle, sweep_done=1, sweep_pass=!fail; then IDLE.
  - sweep_start is ignored during RUN and DONE.
- Undefined: sweep_start ignored; sweep_busy, sweep_done and sweep_pass tied to 0.

Decomposition:
- Package gate_op_pkg holds:
  - op localparams OP_AND..OP_NOT and OP_RSVD (3-bit);
  - SWEEP_VECTORS=28;
  - sweep state encodings S_IDLE, S_RUN, S_DONE.
- Sub-module gate_eval_unit: combinational, inputs op/a/b, outputs y/err. It is instantiated once and muxed between the arbiter and the sweep.

Test Plan:
- Reset then single requester: req 0 sends op=4 (XOR), a=8'hF0, b=8'h3C.
  - Response appears 1 cycle later with rsp_y=8'hCC, rsp_id=0, rsp_err=0.
- All 4 requesters valid continuously, rsp_ready=1:
  - Grants rotate 0,1,2,3,0,… one per cycle.
  - rsp_id follows the same order with 1-cycle lag.
- rsp_ready=0 for 3 cycles with a response pending:
  - rsp_* stable; req_ready all 0.
  - On release, the next grant goes to ptr, not restarting at 0.
- op=7, a=8'hFF, b=8'hFF -> rsp_y=0, rsp_err=1. op=6, a=8'hA5 -> rsp_y=8'h5A.
- rst asserted while a response is pending and rsp_ready=0:
  - Next cycle rsp_valid=0, ptr=0.
  - A req 2 request then gets rsp_id=2.
- With GATE_OP_SCHED_SWEEP_EN, sweep_start with no requests:
  - sweep_busy for 28 cycles, then sweep_done pulse with sweep_pass=1.
  - Repeat with req 1 valid for 5 cycles mid-sweep: completion slips by 5 cycles and the verdict is still pass.
